// File: rtl/uart_rx.sv
// Serial register-access receiver: start bit, 18 payload bits LSB first, stop bit.
// Decodes odd-parity frames into one-cycle write/read strobes with address and data.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       posi,
    output logic       write,
    output logic       read,
    output logic [7:0] write_addr,
    output logic [7:0] write_data,
    output logic [7:0] read_addr,
    output logic       parity_err,
    output logic       framing_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);

    state_t        state;
    logic          posi_m;
    logic          posi_s;
    logic          posi_q;
    logic [TW-1:0] timer;
    logic [4:0]    bit_idx;
    logic [17:0]   shreg;

    // posi_q is the previous synchronized sample, used only for start-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            posi_m <= 1'b1;
            posi_s <= 1'b1;
            posi_q <= 1'b1;
        end else begin
            posi_m <= posi;
            posi_s <= posi_m;
            posi_q <= posi_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            write       <= 1'b0;
            read        <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            read_addr   <= '0;
        end else begin
            write       <= 1'b0;
            read        <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (posi_q && !posi_s) state <= START;
                end
                START: begin
                    if (timer == HALF_M1) begin
                        timer <= '0;
                        state <= posi_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == FULL_M1) begin
                        timer <= '0;
                        shreg <= {posi_s, shreg[17:1]};
                        if (bit_idx == 5'd17) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == FULL_M1) begin
                        timer <= '0;
                        if (!posi_s) begin
                            framing_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end else begin
                            state <= IDLE;
                            if (!(^shreg)) begin
                                parity_err <= 1'b1;
                            end else if (!shreg[0]) begin
                                write      <= 1'b1;
                                write_addr <= shreg[16:9];
                                write_data <= shreg[8:1];
                            end else begin
                                read      <= 1'b1;
                                read_addr <= shreg[16:9];
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (posi_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of frames plus hand-built timing sequences.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       posi = 1'b1;
    logic       write, read, parity_err, framing_err;
    logic [7:0] write_addr, write_data, read_addr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .posi       (posi),
        .write      (write),
        .read       (read),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .parity_err (parity_err),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cnt_w = 0, cnt_r = 0, cnt_p = 0, cnt_f = 0;
    int s_w, s_r, s_p, s_f;
    time t_strobe = 0;
    logic [7:0] strobe_waddr = '0, strobe_wdata = '0;

    always @(negedge clk) begin
        if (write) begin
            cnt_w++;
            t_strobe     = $time;
            strobe_waddr = write_addr;
            strobe_wdata = write_data;
        end
        if (read) begin
            cnt_r++;
            t_strobe = $time;
        end
        if (parity_err)  cnt_p++;
        if (framing_err) cnt_f++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_w = cnt_w; s_r = cnt_r; s_p = cnt_p; s_f = cnt_f;
    endtask

    task automatic check_pulses(input string name, input int ew, input int er, input int ep, input int ef);
        check({name, ".write"},       cnt_w - s_w, ew);
        check({name, ".read"},        cnt_r - s_r, er);
        check({name, ".parity_err"},  cnt_p - s_p, ep);
        check({name, ".framing_err"}, cnt_f - s_f, ef);
    endtask

    task automatic check_regs(input string name, input int wa, input int wd, input int ra);
        check({name, ".write_addr"}, int'(write_addr), wa);
        check({name, ".write_data"}, int'(write_data), wd);
        check({name, ".read_addr"},  int'(read_addr),  ra);
    endtask

    task automatic drive_bit(input logic b);
        posi = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [17:0] pl, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 18; i++) drive_bit(pl[i]);
        drive_bit(stop);
    endtask

    function automatic logic [17:0] payload(input logic [7:0] addr, input logic [7:0] data,
                                            input logic wrb, input logic par);
        return {par, addr, data, wrb};
    endfunction

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wrb;
        logic       par;
        logic       stop;
        int         ew, er, ep, ef;
        logic [7:0] ewa, ewd, era;
    } vec_t;

    vec_t vecs[7];
    time  t0;
    logic [17:0] pl;

    initial begin
        vecs[0] = '{8'h05, 8'hA3, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 8'h05, 8'hA3, 8'h00};
        vecs[1] = '{8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 8'h05, 8'hA3, 8'h0F};
        vecs[2] = '{8'h05, 8'hA3, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0, 8'h05, 8'hA3, 8'h0F};
        vecs[3] = '{8'h3C, 8'h5A, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 8'h3C, 8'h5A, 8'h0F};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 8'h3C, 8'h5A, 8'hFF};
        vecs[5] = '{8'h05, 8'hA3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 8'h3C, 8'h5A, 8'hFF};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 8'h80, 8'h01, 8'hFF};

        // reset state
        repeat (3) @(negedge clk);
        check("rst.write", int'(write), 0);
        check("rst.read", int'(read), 0);
        check("rst.parity_err", int'(parity_err), 0);
        check("rst.framing_err", int'(framing_err), 0);
        check_regs("rst", 8'h00, 8'h00, 8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            snap();
            send_frame(payload(vecs[i].addr, vecs[i].data, vecs[i].wrb, vecs[i].par), vecs[i].stop);
            posi = 1'b1;
            repeat (6) @(negedge clk);
            check_pulses($sformatf("vec%0d", i), vecs[i].ew, vecs[i].er, vecs[i].ep, vecs[i].ef);
            check_regs($sformatf("vec%0d", i), vecs[i].ewa, vecs[i].ewd, vecs[i].era);
            if (vecs[i].ew == 1) begin
                check($sformatf("vec%0d.strobe_addr", i), int'(strobe_waddr), int'(vecs[i].ewa));
                check($sformatf("vec%0d.strobe_data", i), int'(strobe_wdata), int'(vecs[i].ewd));
            end
        end

        // latency: start edge to strobe, 2 sync + detect + half bit + 18 bits + stop
        snap();
        t0 = $time;
        send_frame(payload(8'h12, 8'h34, 1'b0, 1'b0), 1'b1);
        posi = 1'b1;
        repeat (6) @(negedge clk);
        check_pulses("lat", 1, 0, 0, 0);
        check("lat.cycles", int'(t_strobe - t0), 1590);
        check_regs("lat", 8'h12, 8'h34, 8'hFF);

        // back-to-back frames with no idle gap
        snap();
        send_frame(payload(8'hAB, 8'hCD, 1'b0, 1'b1), 1'b1);
        send_frame(payload(8'h77, 8'h00, 1'b1, 1'b0), 1'b1);
        posi = 1'b1;
        repeat (6) @(negedge clk);
        check_pulses("b2b", 1, 1, 0, 0);
        check_regs("b2b", 8'hAB, 8'hCD, 8'h77);

        // framing error with line held low, then a valid frame
        snap();
        send_frame(payload(8'h05, 8'hA3, 1'b0, 1'b1), 1'b0);
        repeat (40) @(negedge clk);
        check_pulses("hold", 0, 0, 0, 1);
        posi = 1'b1;
        repeat (10) @(negedge clk);
        snap();
        send_frame(payload(8'h3C, 8'h5A, 1'b0, 1'b1), 1'b1);
        posi = 1'b1;
        repeat (6) @(negedge clk);
        check_pulses("after_hold", 1, 0, 0, 0);
        check_regs("after_hold", 8'h3C, 8'h5A, 8'h77);

        // 2-cycle glitch on idle line
        snap();
        posi = 1'b0;
        repeat (2) @(negedge clk);
        posi = 1'b1;
        repeat (20) @(negedge clk);
        check_pulses("glitch", 0, 0, 0, 0);
        check_regs("glitch", 8'h3C, 8'h5A, 8'h77);
        snap();
        send_frame(payload(8'h0F, 8'h00, 1'b1, 1'b0), 1'b1);
        posi = 1'b1;
        repeat (6) @(negedge clk);
        check_pulses("after_glitch", 0, 1, 0, 0);
        check_regs("after_glitch", 8'h3C, 8'h5A, 8'h0F);

        // reset during data bit 10
        snap();
        pl = payload(8'h05, 8'hA3, 1'b0, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 10; i++) drive_bit(pl[i]);
        posi = pl[10];
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst.write", int'(write), 0);
        check("midrst.read", int'(read), 0);
        check("midrst.parity_err", int'(parity_err), 0);
        check("midrst.framing_err", int'(framing_err), 0);
        check_regs("midrst", 8'h00, 8'h00, 8'h00);
        posi = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_pulses("midrst", 0, 0, 0, 0);
        snap();
        send_frame(payload(8'h66, 8'h99, 1'b0, 1'b1), 1'b1);
        posi = 1'b1;
        repeat (6) @(negedge clk);
        check_pulses("after_rst", 1, 0, 0, 0);
        check_regs("after_rst", 8'h66, 8'h99, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
